// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared types and constants for the SRAM access arbiter.
//   - arb_state_t : sequencer states (IDLE, BUSY, RELEASE)
//   - PORT_CACHE / PORT_WRITE : requester indices (cache fill / write path)
//   - DEFAULT_TIMEOUT : default watchdog limit in BUSY cycles
//   - CNT_W : watchdog counter width
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int PORT_CACHE      = 0;
  localparam int PORT_WRITE      = 1;
  localparam int DEFAULT_TIMEOUT = 255;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/sram_access_arbiter_rr_grant2.sv
// rr_grant2
//   Two-input round-robin picker. Holds the index of the last granted port
//   and, when both inputs request, picks the other one.
//   Ports:
//     clk, rst     : clock, asynchronous active-low reset
//     req[1:0]     : request vector (bit 0 = port 0, bit 1 = port 1)
//     grant_en     : commit the current pick into last_grant
//     grant_valid  : at least one request present
//     grant_idx    : index of the picked port
module rr_grant2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic last_grant_q;
  logic last_grant_d;

  // Contention goes to the port that was not served last; a lone request
  // simply wins.
  always_comb begin
    grant_valid = |req;
    if (req[0] && req[1]) begin
      grant_idx = ~last_grant_q;
    end else begin
      grant_idx = req[1];
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_en && grant_valid) begin
      last_grant_d = grant_idx;
    end
  end

  // Reset to 1 so that port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
//   Shares one SRAM controller between the cache-fill port (0) and the
//   write-through port (1). Latches one request at a time, drives the
//   controller handshake in BUSY until mem_ready or watchdog expiry, then
//   pulses the granted port's ack in RELEASE with rdata/err.
//   Ports:
//     clk, rst                  : clock, asynchronous active-low reset
//     req*/we*/addr*/wdata*     : requester inputs, ports 0 and 1
//     ack0, ack1                : one-cycle completion pulses
//     err, rdata                : completion status / read data (held)
//     mem_rd_en, mem_wr_en      : controller enables (BUSY only)
//     mem_address, mem_wdata    : latched request towards controller
//     mem_rdata, mem_ready      : controller response
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic grant_valid;
  logic grant_idx;

  rr_grant2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         ({req1, req0}),
    .grant_en    (state_q == IDLE),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // State register and datapath latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. The watchdog counter starts at 0 in the first BUSY
  // cycle, so expiry at TIMEOUT_CNT means TIMEOUT+1 BUSY cycles in total;
  // mem_ready is checked first so it wins on the final count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = BUSY;
      BUSY:    if (mem_ready || (cnt_q == TIMEOUT_CNT)) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the granted request in IDLE, count and capture the
  // response in BUSY. rdata/err otherwise hold until the next completion.
  always_comb begin
    cnt_d   = cnt_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          port_d  = grant_idx;
          we_d    = grant_idx ? we1 : we0;
          addr_d  = grant_idx ? addr1 : addr0;
          wdata_d = grant_idx ? wdata1 : wdata0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
          err_d   = 1'b0;
        end else if (cnt_q == TIMEOUT_CNT) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs are decoded from registered state only, so nothing here
  // depends combinationally on the request inputs.
  always_comb begin
    mem_rd_en   = (state_q == BUSY) && !we_q;
    mem_wr_en   = (state_q == BUSY) && we_q;
    ack0        = (state_q == RELEASE) && (port_q == 1'(PORT_CACHE));
    ack1        = (state_q == RELEASE) && (port_q == 1'(PORT_WRITE));
    err         = err_q;
    rdata       = rdata_q;
    mem_address = addr_q;
    mem_wdata   = wdata_q;
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter
//   Directed and randomized transactions against a behavioural model of the
//   arbiter: round-robin choice, BUSY length min(latency, TIMEOUT+1), error
//   on missing mem_ready, and rdata capture. A small SRAM responder raises
//   mem_ready on a programmed BUSY cycle (0 = never).
module tb_sram_access_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err, mem_rd_en, mem_wr_en;
  logic [31:0] rdata, mem_address, mem_wdata, mem_rdata;
  logic        mem_ready = 1'b0;

  int          lat_cfg = 0;
  logic [31:0] rd_cfg = '0;
  int          busy_seen = 0;
  int          checks = 0;
  int          errors = 0;
  bit          model_last = 1'b1;

  always #5 clk = ~clk;

  assign mem_rdata = rd_cfg;

  sram_access_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // SRAM responder: counts enabled cycles and raises mem_ready on the
  // lat_cfg-th one.
  always @(negedge clk) begin
    if (mem_rd_en || mem_wr_en) begin
      busy_seen = busy_seen + 1;
      mem_ready = (busy_seen == lat_cfg);
    end else begin
      busy_seen = 0;
      mem_ready = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the DUT is IDLE; returns at the following
  // IDLE negedge after the ack.
  task automatic applyStimulus(input string tag, input bit r0, input bit r1,
                               input bit w0, input bit w1,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input int lat, input logic [31:0] rd, input bit hold);
    int port, ncyc, en_cyc, exp_port, exp_busy;
    bit saw_wr, exp_err, exp_we, ack_en;
    logic [31:0] seen_addr, seen_wdata, exp_rdata;
    lat_cfg = lat; rd_cfg = rd;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    exp_port  = (r0 && r1) ? (model_last ? 0 : 1) : (r1 ? 1 : 0);
    exp_err   = !(lat >= 1 && lat <= T + 1);
    exp_busy  = exp_err ? T + 1 : lat;
    exp_we    = exp_port ? w1 : w0;
    exp_rdata = exp_err ? 32'h0 : rd;
    port = -1; ncyc = 0; en_cyc = 0; saw_wr = 0; ack_en = 0;
    seen_addr = '0; seen_wdata = '0;
    while (port < 0 && ncyc < T + 6) begin
      @(negedge clk);
      ncyc++;
      if (mem_rd_en || mem_wr_en) begin
        en_cyc++;
        saw_wr = mem_wr_en;
        seen_addr = mem_address;
        seen_wdata = mem_wdata;
      end
      if (ack0 || ack1) begin
        port = ack1 ? 1 : 0;
        ack_en = mem_rd_en || mem_wr_en;
        checkOutput({tag, "_ack_both"}, {31'b0, ack0 && ack1}, 32'd0);
      end
    end
    checkOutput({tag, "_port"}, 32'(port), 32'(exp_port));
    checkOutput({tag, "_latency"}, 32'(ncyc), 32'(exp_busy + 1));
    checkOutput({tag, "_en_cycles"}, 32'(en_cyc), 32'(exp_busy));
    checkOutput({tag, "_we"}, {31'b0, saw_wr}, {31'b0, exp_we});
    checkOutput({tag, "_addr"}, seen_addr, exp_port ? a1 : a0);
    checkOutput({tag, "_wdata"}, seen_wdata, exp_port ? d1 : d0);
    checkOutput({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    checkOutput({tag, "_rdata"}, rdata, exp_rdata);
    checkOutput({tag, "_en_at_ack"}, {31'b0, ack_en}, 32'd0);
    model_last = exp_port[0];
    if (!hold) begin
      req0 = 1'b0; req1 = 1'b0;
    end
    @(negedge clk);
    checkOutput({tag, "_ack_pulse"}, {31'b0, ack0 || ack1}, 32'd0);
    checkOutput({tag, "_idle_gap"}, {31'b0, mem_rd_en || mem_wr_en}, 32'd0);
    checkOutput({tag, "_rdata_hold"}, rdata, exp_rdata);
    checkOutput({tag, "_err_hold"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  initial begin
    int acks_seen;
    bit rr0, rr1;

    // Reset state
    @(negedge clk); @(negedge clk);
    checkOutput("rst_ack0", {31'b0, ack0}, 32'd0);
    checkOutput("rst_ack1", {31'b0, ack1}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_en", {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
    checkOutput("rst_addr", mem_address, 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b1;
    model_last = 1'b1;
    @(negedge clk);

    $display("[TB] single read / single write");
    applyStimulus("rd0", 1, 0, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, 1, 32'hDEADBEEF, 0);
    applyStimulus("wr1", 0, 1, 0, 1, 32'h0, 32'h80, 32'h0, 32'h12345678, 5, 32'hA5A5A5A5, 0);

    $display("[TB] continuous contention");
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("rr%0d", i), 1, 1, 0, 1, 32'h100 + i, 32'h200 + i,
                    32'h11 + i, 32'h22 + i, 1, 32'hC0DE0000 + i, (i < 3));
    end

    $display("[TB] watchdog");
    applyStimulus("tmo", 1, 0, 0, 0, 32'h300, 32'h0, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 0);
    applyStimulus("after_tmo", 1, 0, 0, 0, 32'h304, 32'h0, 32'h0, 32'h0, 2, 32'h0BADF00D, 0);
    applyStimulus("coincide", 0, 1, 0, 0, 32'h0, 32'h308, 32'h0, 32'h0, T + 1, 32'h5EED5EED, 0);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 24; i++) begin
      rr0 = 1'($urandom_range(0, 1));
      rr1 = 1'($urandom_range(0, 1));
      if (!rr0 && !rr1) rr0 = 1'b1;
      applyStimulus($sformatf("rnd%0d", i), rr0, rr1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 11)), $urandom, 0);
    end

    $display("[TB] reset mid-BUSY");
    lat_cfg = 0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h400; wdata1 = 32'h77;
    repeat (4) @(negedge clk);
    checkOutput("mid_busy_wr_en", {31'b0, mem_wr_en}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_en", {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
    checkOutput("async_rst_ack", {30'b0, ack0, ack1}, 32'd0);
    checkOutput("async_rst_addr", mem_address, 32'd0);
    checkOutput("async_rst_rdata", rdata, 32'd0);
    req1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_last = 1'b1;
    acks_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack0 || ack1) acks_seen++;
    end
    checkOutput("no_ack_after_rst", 32'(acks_seen), 32'd0);
    applyStimulus("post_rst_rr", 1, 1, 0, 0, 32'h500, 32'h600, 32'h0, 32'h0, 1, 32'h13579BDF, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
